// File: rtl/cart_mem_arbiter.sv
// Cartridge memory port arbiter: loader and two slots share one
// 8-bit req/ready memory port, one transaction outstanding at a time.
module cart_mem_arbiter #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    input  logic              s0_req,
    input  logic              s0_we,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [7:0]        s0_din,
    output logic [7:0]        s0_dout,
    output logic              s0_ack,
    output logic              s0_wait,
    input  logic              s1_req,
    input  logic              s1_we,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [7:0]        s1_din,
    output logic [7:0]        s1_dout,
    output logic              s1_ack,
    output logic              s1_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ready,
    input  logic [7:0]        mem_dout
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_LD, OWN_S0, OWN_S1} owner_t;

    state_t state, state_nx;
    owner_t owner;

    logic              ld_pend, s0_pend, s1_pend;
    logic [ADDR_W-1:0] ld_addr_q, s0_addr_q, s1_addr_q;
    logic [7:0]        ld_data_q, s0_din_q, s1_din_q;
    logic              s0_we_q, s1_we_q;
    logic              rr;
    logic              grant_ld, grant_s0, grant_s1, done;

    assign ld_busy = ld_pend;
    assign s0_wait = s0_pend;
    assign s1_wait = s1_pend;

    // rr holds the last slot served: 1 means slot 0 wins the next tie
    always_comb begin
        state_nx = state;
        grant_ld = 1'b0;
        grant_s0 = 1'b0;
        grant_s1 = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_pend)
                    grant_ld = 1'b1;
                else if (s0_pend && (!s1_pend || rr))
                    grant_s0 = 1'b1;
                else if (s1_pend)
                    grant_s1 = 1'b1;
                if (ld_pend || s0_pend || s1_pend)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (!mem_req && mem_ready) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_pend   <= 1'b0;
            s0_pend   <= 1'b0;
            s1_pend   <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
            s0_we_q   <= 1'b0;
            s0_addr_q <= '0;
            s0_din_q  <= '0;
            s1_we_q   <= 1'b0;
            s1_addr_q <= '0;
            s1_din_q  <= '0;
        end else begin
            if (!ld_pend) begin
                ld_pend <= ld_wr;
                if (ld_wr) begin
                    ld_addr_q <= ld_addr;
                    ld_data_q <= ld_data;
                end
            end else if (done && owner == OWN_LD) begin
                ld_pend <= 1'b0;
            end
            if (!s0_pend) begin
                s0_pend <= s0_req;
                if (s0_req) begin
                    s0_we_q   <= s0_we;
                    s0_addr_q <= s0_addr;
                    s0_din_q  <= s0_din;
                end
            end else if (done && owner == OWN_S0) begin
                s0_pend <= 1'b0;
            end
            if (!s1_pend) begin
                s1_pend <= s1_req;
                if (s1_req) begin
                    s1_we_q   <= s1_we;
                    s1_addr_q <= s1_addr;
                    s1_din_q  <= s1_din;
                end
            end else if (done && owner == OWN_S1) begin
                s1_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= OWN_LD;
            rr       <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            s0_ack   <= 1'b0;
            s1_ack   <= 1'b0;
            s0_dout  <= 8'hFF;
            s1_dout  <= 8'hFF;
        end else begin
            mem_req <= grant_ld || grant_s0 || grant_s1;
            s0_ack  <= done && owner == OWN_S0;
            s1_ack  <= done && owner == OWN_S1;
            if (grant_ld) begin
                owner    <= OWN_LD;
                mem_we   <= 1'b1;
                mem_addr <= ld_addr_q;
                mem_din  <= ld_data_q;
            end
            if (grant_s0) begin
                owner    <= OWN_S0;
                rr       <= 1'b0;
                mem_we   <= s0_we_q;
                mem_addr <= s0_addr_q;
                mem_din  <= s0_din_q;
            end
            if (grant_s1) begin
                owner    <= OWN_S1;
                rr       <= 1'b1;
                mem_we   <= s1_we_q;
                mem_addr <= s1_addr_q;
                mem_din  <= s1_din_q;
            end
            if (done && !mem_we && owner == OWN_S0)
                s0_dout <= mem_dout;
            if (done && !mem_we && owner == OWN_S1)
                s1_dout <= mem_dout;
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a request-level reference model.
module tb_cart_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_wr = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_busy;
    logic        s0_req = 1'b0, s0_we = 1'b0;
    logic [24:0] s0_addr = '0;
    logic [7:0]  s0_din = '0;
    logic [7:0]  s0_dout;
    logic        s0_ack, s0_wait;
    logic        s1_req = 1'b0, s1_we = 1'b0;
    logic [24:0] s1_addr = '0;
    logic [7:0]  s1_din = '0;
    logic [7:0]  s1_dout;
    logic        s1_ack, s1_wait;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_dout = '0;

    cart_mem_arbiter #(.ADDR_W(25)) dut (
        .clk(clk), .reset(reset),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_busy(ld_busy),
        .s0_req(s0_req), .s0_we(s0_we), .s0_addr(s0_addr),
        .s0_din(s0_din), .s0_dout(s0_dout), .s0_ack(s0_ack),
        .s0_wait(s0_wait),
        .s1_req(s1_req), .s1_we(s1_we), .s1_addr(s1_addr),
        .s1_din(s1_din), .s1_dout(s1_dout), .s1_ack(s1_ack),
        .s1_wait(s1_wait),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_ready(mem_ready), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: index 0 = loader, 1 = slot 0, 2 = slot 1
    bit          m_pend[3];
    bit          m_we[3];
    logic [24:0] m_addr[3];
    logic [7:0]  m_data[3];
    bit          m_txn, m_reqph;
    int          m_own, m_last;
    logic [7:0]  m_dout[2];
    bit          m_ack[2];
    logic        e_we;
    logic [24:0] e_addr;
    logic [7:0]  e_din;

    // memory responder
    bit          armed = 0;
    int          cnt = 0;
    int          delay = 0;
    bit          rnd_mode = 0;
    logic [7:0]  next_rd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pend[i] = 0;
        m_txn = 0; m_reqph = 0; m_own = 0; m_last = 2;
        m_dout[0] = 8'hFF; m_dout[1] = 8'hFF;
        m_ack[0] = 0; m_ack[1] = 0;
        e_we = 0; e_addr = '0; e_din = '0;
    endtask

    task automatic model_edge();
        bit          op[3];
        bit          stb[3];
        bit          swe[3];
        logic [24:0] sa[3];
        logic [7:0]  sd[3];
        int          w;
        stb = '{ld_wr, s0_req, s1_req};
        swe = '{1'b1, s0_we, s1_we};
        sa  = '{ld_addr, s0_addr, s1_addr};
        sd  = '{ld_data, s0_din, s1_din};
        for (int i = 0; i < 3; i++) op[i] = m_pend[i];
        m_ack[0] = 0; m_ack[1] = 0;
        if (m_txn) begin
            if (m_reqph) m_reqph = 0;
            else if (mem_ready) begin
                if (m_own > 0) begin
                    m_ack[m_own-1] = 1;
                    if (!e_we) m_dout[m_own-1] = mem_dout;
                end
                m_pend[m_own] = 0;
                m_txn = 0;
            end
        end else if (op[0] || op[1] || op[2]) begin
            if (op[0]) w = 0;
            else if (op[1] && op[2]) w = (m_last == 1) ? 2 : 1;
            else w = op[1] ? 1 : 2;
            e_we = m_we[w]; e_addr = m_addr[w]; e_din = m_data[w];
            m_own = w; m_txn = 1; m_reqph = 1;
            if (w != 0) m_last = w;
        end
        for (int i = 0; i < 3; i++)
            if (!op[i] && stb[i]) begin
                m_pend[i] = 1; m_we[i] = swe[i];
                m_addr[i] = sa[i]; m_data[i] = sd[i];
            end
    endtask

    task automatic check_all();
        chk("ld_busy", ld_busy, m_pend[0]);
        chk("s0_wait", s0_wait, m_pend[1]);
        chk("s1_wait", s1_wait, m_pend[2]);
        chk("mem_req", mem_req, m_reqph);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_din", mem_din, e_din);
        chk("s0_ack", s0_ack, m_ack[0]);
        chk("s1_ack", s1_ack, m_ack[1]);
        chk("s0_dout", s0_dout, m_dout[0]);
        chk("s1_dout", s1_dout, m_dout[1]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_edge();
        check_all();
        ld_wr = 0; s0_req = 0; s1_req = 0;
        mem_ready = 0;
        if (mem_req) begin
            armed = 1;
            cnt = rnd_mode ? int'($urandom_range(0, 3)) : delay;
        end else if (armed) begin
            if (cnt == 0) begin
                mem_ready = 1;
                mem_dout = rnd_mode ? 8'($urandom) : next_rd;
                armed = 0;
            end else cnt--;
        end
        if (rnd_mode && $urandom_range(0, 7) == 0) begin
            mem_ready = 1;
            mem_dout = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1; armed = 0; mem_ready = 0;
        step(); step();
        reset = 0;
    endtask

    task automatic slot_rd(input int s, input logic [24:0] a);
        if (s == 0) begin s0_req = 1; s0_we = 0; s0_addr = a; end
        else begin s1_req = 1; s1_we = 0; s1_addr = a; end
    endtask

    initial begin
        int ack_at, req_n, wait_n, first, g_ld, g_s0, fall;
        int exp_first[4];
        model_reset();
        do_reset();
        chk("rst_s0_dout", s0_dout, 8'hFF);
        chk("rst_s1_dout", s1_dout, 8'hFF);
        chk("rst_mem_req", mem_req, 1'b0);

        // single slot-0 read, zero-wait memory
        delay = 0; next_rd = 8'hA5;
        slot_rd(0, 25'h012345);
        step();
        ack_at = -1; req_n = 0; wait_n = s0_wait ? 1 : 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (s0_ack) ack_at = i;
            if (s0_wait) wait_n++;
            if (mem_req) begin
                req_n++;
                chk("t1_addr", mem_addr, 25'h012345);
                chk("t1_we", mem_we, 1'b0);
            end
        end
        chk("t1_ack_at", ack_at, 3);
        chk("t1_req_cycles", req_n, 1);
        chk("t1_wait_cycles", wait_n, 3);
        chk("t1_dout", s0_dout, 8'hA5);

        // round-robin between slots
        do_reset();
        exp_first = '{1, 2, 2, 1};
        for (int r = 0; r < 4; r++) begin
            if (r == 1 || r == 3) begin
                slot_rd(r == 1 ? 0 : 1, 25'h000300);
                for (int i = 0; i < 6; i++) step();
            end
            slot_rd(0, 25'h000100 + 25'(r));
            slot_rd(1, 25'h000200 + 25'(r));
            first = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (mem_req && first == 0)
                    first = (mem_addr[9:8] == 2'b01) ? 1 : 2;
            end
            chk("t2_first_slot", first, exp_first[r]);
        end

        // loader beats a simultaneous slot read
        do_reset();
        ld_wr = 1; ld_addr = 25'h000100; ld_data = 8'h3C;
        slot_rd(0, 25'h000444);
        step();
        g_ld = -1; g_s0 = -1; fall = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mem_req && g_ld < 0) begin
                g_ld = i;
                chk("t3_ld_we", mem_we, 1'b1);
                chk("t3_ld_din", mem_din, 8'h3C);
                chk("t3_ld_addr", mem_addr, 25'h000100);
            end else if (mem_req) g_s0 = i;
            if (!ld_busy && fall < 0) fall = i;
        end
        chk("t3_ld_grant", g_ld, 1);
        chk("t3_busy_fall", fall, 3);
        chk("t3_s0_grant", g_s0, 4);

        // delayed slot-1 write with an ignored re-strobe
        do_reset();
        delay = 10;
        s1_req = 1; s1_we = 1; s1_addr = 25'h1FFFFFF; s1_din = 8'h77;
        step();
        wait_n = 1; req_n = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 5) begin
                s1_req = 1; s1_we = 1; s1_addr = 25'h0000AA;
            end
            step();
            if (s1_wait) wait_n++;
            if (mem_req) req_n++;
        end
        chk("t4_wait_cycles", wait_n, 13);
        chk("t4_req_count", req_n, 1);
        chk("t4_dout", s1_dout, 8'hFF);

        // reset mid-transaction, stale ready afterwards
        do_reset();
        delay = 3; next_rd = 8'h5A;
        slot_rd(0, 25'h000777);
        step(); step();
        chk("t5_req_before", mem_req, 1'b1);
        reset = 1;
        #1;
        chk("t5_req_async", mem_req, 1'b0);
        step(); step();
        reset = 0;
        req_n = 0; ack_at = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mem_req) req_n++;
            if (s0_ack || s1_ack) ack_at++;
        end
        chk("t5_req_count", req_n, 0);
        chk("t5_ack_count", ack_at, 0);
        chk("t5_s0_wait", s0_wait, 1'b0);
        chk("t5_s0_dout", s0_dout, 8'hFF);

        // spurious ready in IDLE and during the request cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1; mem_dout = 8'h11;
            step();
        end
        delay = 2; next_rd = 8'h42;
        slot_rd(0, 25'h000888);
        step();
        ack_at = -1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin mem_ready = 1; mem_dout = 8'h99; end
            step();
            if (s0_ack) ack_at = i;
        end
        chk("t6_ack_at", ack_at, 5);
        chk("t6_dout", s0_dout, 8'h42);

        // random traffic
        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                ld_wr = 1; ld_addr = 25'($urandom); ld_data = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                s0_req = 1; s0_we = 1'($urandom);
                s0_addr = 25'($urandom); s0_din = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                s1_req = 1; s1_we = 1'($urandom);
                s1_addr = 25'($urandom); s1_din = 8'($urandom);
            end
            if (i == 300) begin
                reset = 1;
                step();
                reset = 0;
            end else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
